// File: rtl/day1_pkg.sv
// Shared constants, state encoding and helpers for the day1 front end.
// ASCII codes match the puzzle text format ("L68\n" / "R14\n").
package day1_pkg;

    localparam logic [7:0] CHAR_L  = 8'h4C;
    localparam logic [7:0] CHAR_R  = 8'h52;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_9  = 8'h39;

    localparam int DIAL_SIZE     = 100;
    localparam int MAG_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        DIGITS,
        SKIP,
        DONE
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CHAR_0) && (b <= CHAR_9);
    endfunction

endpackage

// File: rtl/day1_parser_if.sv
// Byte-stream handshake into the day1 parser.
// master = byte source (FIFO/UART), slave = parser.
interface day1_parser_if;

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        input  byte_last,
        output byte_ready
    );

endinterface

// File: rtl/day1_dec_accum.sv
// Decimal accumulate datapath: acc*10+digit with saturation.
// value is the saturated magnitude of the next accumulator state.
module day1_dec_accum #(
    parameter int MAG_WIDTH  = 16,
    parameter int MAX_DIGITS = 5,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 clear,
    input  logic                 digit_en,
    input  logic [3:0]           digit,
    output logic [MAG_WIDTH-1:0] value,
    output logic [CNT_W-1:0]     count
);

    localparam int AW = MAG_WIDTH + 4;
    localparam int PW = AW + 4;

    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    acc_d;
    logic [PW-1:0]    wide;
    logic [PW-1:0]    prod;
    logic [CNT_W-1:0] cnt_d;

    // PW bits always hold 10*(2^AW-1)+9, so the clamp test is exact
    always_comb begin
        wide  = {4'b0, acc_q};
        prod  = (wide << 3) + (wide << 1) + PW'(digit);
        acc_d = acc_q;
        cnt_d = count;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (digit_en) begin
            acc_d = (|prod[PW-1:AW]) ? '1 : prod[AW-1:0];
            cnt_d = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            acc_q <= '0;
            count <= '0;
        end else begin
            acc_q <= acc_d;
            count <= cnt_d;
        end
    end

    assign value = (|acc_d[AW-1:MAG_WIDTH]) ? '1 : acc_d[MAG_WIDTH-1:0];

endmodule

// File: rtl/day1_parser.sv
// Byte-stream parser producing day1 dial instructions.
// Optional stats counters: define DAY1_PARSER_STATS_EN.
module day1_parser
    import day1_pkg::*;
#(
    parameter int MAG_WIDTH  = MAG_WIDTH_DEF,
    parameter int MAX_DIGITS = 5
) (
    input  logic                 clock,
    input  logic                 clear_n,
    day1_parser_if.slave         byte_bus,
    output logic                 direction,
    output logic [MAG_WIDTH-1:0] magnitude,
    output logic                 instruction_valid,
    output logic                 parse_error,
    output logic                 done
`ifdef DAY1_PARSER_STATS_EN
    ,
    output logic [31:0]          line_count,
    output logic [15:0]          error_count
`endif
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_t               state_q;
    state_t               state_d;
    logic                 rdy_q;
    logic                 dir_pend_q;
    logic                 accept;
    logic                 acc_clr;
    logic                 dig_en;
    logic                 dir_ld;
    logic                 emit;
    logic                 err;
    logic                 is_dig;
    logic                 full;
    logic                 has;
    logic [7:0]           b;
    logic [MAG_WIDTH-1:0] value;
    logic [CNT_W-1:0]     count;

    day1_dec_accum #(
        .MAG_WIDTH  (MAG_WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (CNT_W)
    ) u_accum (
        .clock    (clock),
        .clear_n  (clear_n),
        .clear    (acc_clr),
        .digit_en (dig_en),
        .digit    (b[3:0]),
        .value    (value),
        .count    (count)
    );

    assign b      = byte_bus.byte_data;
    assign accept = byte_bus.byte_valid & byte_bus.byte_ready;
    assign is_dig = is_digit(b);
    assign full   = (count == CNT_W'(MAX_DIGITS));
    assign has    = (count != '0);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        acc_clr = 1'b0;
        dig_en  = 1'b0;
        dir_ld  = 1'b0;
        emit    = 1'b0;
        err     = 1'b0;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (b == CHAR_L || b == CHAR_R) begin
                        state_d = DIGITS;
                        acc_clr = 1'b1;
                        dir_ld  = 1'b1;
                    end else if (b != CHAR_LF && b != CHAR_CR) begin
                        err     = 1'b1;
                        state_d = SKIP;
                    end
                end
                DIGITS: begin
                    unique case (1'b1)
                        is_dig: begin
                            if (full) begin
                                err     = 1'b1;
                                state_d = SKIP;
                            end else begin
                                dig_en  = 1'b1;
                            end
                        end
                        (b == CHAR_CR): ;
                        (b == CHAR_LF): begin
                            emit    = has;
                            err     = !has;
                            state_d = IDLE;
                        end
                        default: begin
                            err     = 1'b1;
                            state_d = SKIP;
                        end
                    endcase
                end
                SKIP: begin
                    if (b == CHAR_LF) state_d = IDLE;
                end
                DONE: ;
            endcase
            // final byte flushes a pending line lacking its newline
            if (byte_bus.byte_last) begin
                state_d = DONE;
                if (state_q == DIGITS && !err && (has || dig_en))
                    emit = 1'b1;
            end
        end
    end

    always_comb begin
        byte_bus.byte_ready = rdy_q && (state_q != DONE);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            rdy_q             <= 1'b0;
            dir_pend_q        <= 1'b0;
            direction         <= 1'b0;
            magnitude         <= '0;
            instruction_valid <= 1'b0;
            parse_error       <= 1'b0;
            done              <= 1'b0;
        end else begin
            rdy_q             <= 1'b1;
            instruction_valid <= emit;
            parse_error       <= err;
            if (dir_ld) dir_pend_q <= (b == CHAR_R);
            if (emit) begin
                direction <= dir_pend_q;
                magnitude <= value;
            end
            if (accept && byte_bus.byte_last) done <= 1'b1;
        end
    end

`ifdef DAY1_PARSER_STATS_EN
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            line_count  <= '0;
            error_count <= '0;
        end else begin
            if (instruction_valid) line_count <= line_count + 32'd1;
            if (parse_error && error_count != 16'hFFFF)
                error_count <= error_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_day1_parser.sv
// Scoreboard bench for day1_parser: line-level reference model,
// directed plan streams plus randomized streams with valid gaps.
module tb_day1_parser;

    typedef logic [7:0] u8;

    typedef struct {
        bit is_err;
        bit dir;
        int mag;
        bit fin;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        direction;
    logic [15:0] magnitude;
    logic        instruction_valid;
    logic        parse_error;
    logic        done;
`ifdef DAY1_PARSER_STATS_EN
    logic [31:0] line_count;
    logic [15:0] error_count;
`endif

    always #5 clock = ~clock;

    day1_parser_if bus ();

    day1_parser dut (
        .clock             (clock),
        .clear_n           (clear_n),
        .byte_bus          (bus),
        .direction         (direction),
        .magnitude         (magnitude),
        .instruction_valid (instruction_valid),
        .parse_error       (parse_error),
        .done              (done)
`ifdef DAY1_PARSER_STATS_EN
        ,
        .line_count        (line_count),
        .error_count       (error_count)
`endif
    );

    exp_t exp_q[$];
    u8    stream[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    function automatic void add_str(input string s);
        for (int i = 0; i < s.len(); i++) stream.push_back(u8'(s[i]));
    endfunction

    function automatic void push_exp(input bit is_err, input bit dir,
                                     input int mag, input bit fin);
        exp_t e;
        e.is_err = is_err;
        e.dir    = dir;
        e.mag    = mag;
        e.fin    = fin;
        exp_q.push_back(e);
    endfunction

    // one line, CRs already removed: letter, then 1..5 digits
    function automatic void classify(input u8 line[$], input bit complete,
                                     input bit fin);
        int v = 0;
        bit bad = 0;
        int nd;
        if (line.size() == 0) return;
        if (line[0] != "L" && line[0] != "R") begin
            push_exp(1, 0, 0, fin);
            return;
        end
        nd = line.size() - 1;
        for (int i = 1; i < line.size(); i++) begin
            if (line[i] < "0" || line[i] > "9") bad = 1;
            else v = v * 10 + int'(line[i] - "0");
        end
        if (bad || nd > 5) push_exp(1, 0, 0, fin);
        else if (nd == 0) begin
            if (complete) push_exp(1, 0, 0, fin);
        end else begin
            push_exp(0, line[0] == "R", (v > 65535) ? 65535 : v, fin);
        end
    endfunction

    function automatic void model(input bit ended);
        u8 cur[$];
        for (int i = 0; i < stream.size(); i++) begin
            if (stream[i] == 8'h0A) begin
                classify(cur, 1, ended && i == stream.size() - 1);
                cur.delete();
            end else if (stream[i] != 8'h0D) begin
                cur.push_back(stream[i]);
            end
        end
        if (ended) classify(cur, 0, 1);
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_direction"}, int'(direction), 0);
        check({tag, "_magnitude"}, int'(magnitude), 0);
        check({tag, "_inst_valid"}, int'(instruction_valid), 0);
        check({tag, "_parse_error"}, int'(parse_error), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_byte_ready"}, int'(bus.byte_ready), 0);
    endtask

    task automatic do_reset();
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        bus.byte_data  = 8'h00;
        clear_n = 1'b0;
        #1;
        check_zero_outputs("in_reset");
        @(posedge clock);
        #1;
        exp_q.delete();
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_reset", int'(bus.byte_ready), 1);
    endtask

    // last_pulse >= 0: check instruction_valid/done right after final accept
    task automatic send(input bit ended, input bit gaps, input int last_pulse);
        int t;
        int n = stream.size();
        model(ended);
        for (int i = 0; i < n; i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                bus.byte_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            bus.byte_data  = stream[i];
            bus.byte_last  = ended && (i == n - 1);
            bus.byte_valid = 1'b1;
            t = 0;
            while (!bus.byte_ready && t < 50) begin
                @(posedge clock);
                #1;
                t++;
            end
            if (!bus.byte_ready) begin
                check("ready_timeout", 0, 1);
                break;
            end
            @(posedge clock);
            #1;
            if (ended && i == n - 1 && last_pulse >= 0) begin
                check("last_pulse", int'(instruction_valid), last_pulse);
                check("done_with_last", int'(done), 1);
            end
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        if (ended) begin
            check("done_sticky", int'(done), 1);
            check("ready_after_done", int'(bus.byte_ready), 0);
        end
        stream.delete();
    endtask

    function automatic void add_digits(input int nd, input bit nines);
        for (int k = 0; k < nd; k++)
            stream.push_back(nines ? 8'h39 : u8'(8'h30 + $urandom_range(0, 9)));
    endfunction

    function automatic void gen_line();
        int  k = $urandom_range(0, 9);
        string d = ($urandom_range(0, 1) != 0) ? "R" : "L";
        if (k <= 5) begin
            add_str(d);
            if ($urandom_range(0, 4) == 0) add_str("\015");
            add_digits($urandom_range(1, 5), $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) add_str("\015");
            add_str("\n");
        end else if (k == 6) begin
            if ($urandom_range(0, 1) != 0) add_str("\015");
            add_str("\n");
        end else if (k == 7) begin
            case ($urandom_range(0, 3))
                0: add_str("X");
                1: add_str("a");
                2: add_str(" ");
                default: add_str("7");
            endcase
            add_digits(2, 0);
            add_str("\n");
        end else if (k == 8) begin
            add_str(d);
            add_digits($urandom_range(6, 7), 0);
            add_str("\n");
        end else begin
            add_str(d);
            if ($urandom_range(0, 1) != 0) add_str("\n");
            else begin
                add_digits(1, 0);
                add_str("x");
                add_digits(1, 0);
                add_str("\n");
            end
        end
    endfunction

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        bus.byte_data  = 8'h00;

        fork
            forever begin : monitor
                exp_t e;
                @(negedge clock);
                if (clear_n && (instruction_valid || parse_error)) begin
                    if (instruction_valid && parse_error)
                        check("both_pulses", 1, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", instruction_valid ? 1 : 2, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("is_error", int'(parse_error), int'(e.is_err));
                        if (!e.is_err && instruction_valid) begin
                            check("direction", int'(direction), int'(e.dir));
                            check("magnitude", int'(magnitude), e.mag);
                            check("done_at_emit", int'(done), int'(e.fin));
                        end
                    end
                end
            end
        join_none

        do_reset();
        add_str("L68\nR14\n");
        send(0, 0, -1);

        do_reset();
        add_str("R5\015\n\nL0\n");
        send(1, 0, -1);

        do_reset();
        add_str("X12\nL7\n");
        send(0, 0, -1);

        do_reset();
        add_str("R99999\nR123456\nL65535\n");
        send(0, 1, -1);

        do_reset();
        add_str("L3");
        send(1, 0, 1);

        do_reset();
        add_str("R4");
        send(0, 0, -1);
        do_reset();
        add_str("L1\n");
        send(1, 0, 1);

        for (int s = 0; s < 30; s++) begin
            int tail = $urandom_range(0, 3);
            do_reset();
            for (int l = $urandom_range(2, 8); l > 0; l--) gen_line();
            if (tail == 1) begin
                add_str(($urandom_range(0, 1) != 0) ? "R" : "L");
                add_digits($urandom_range(1, 5), 0);
            end else if (tail == 2) begin
                add_str("L");
            end
            send(tail != 3, ($urandom_range(0, 1) != 0), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/day1_parser.md
Name: day1_parser

Overview:
- Byte-stream front end for the day1 dial solver.
- Consumes raw puzzle text one ASCII byte per handshake, lines of the form "L68\n" / "R14\n".
- Produces the solver's instruction interface: direction, magnitude, and a one-cycle instruction_valid pulse.
- Sits between the input FIFO/UART and the solver; its outputs wire directly to the solver's instruction ports.

Parameters:
- MAG_WIDTH, 16, width of the magnitude output; matches the solver's magnitude port.
- MAX_DIGITS, 5, maximum decimal digits accepted per line; extra digits are a parse error.

Ports:
- clock  in  1  single system clock; all state on rising edge.
- clear_n  in  1  asynchronous active-low reset.
- byte_data  in  8  ASCII input byte.
- byte_valid  in  1  byte_data is valid.
- byte_last  in  1  qualifies the final byte of the input; sampled only on accept.
- byte_ready  out  1  parser can accept a byte.
- direction  out  1  1 = 'R' (clockwise, add), 0 = 'L'.
- magnitude  out  MAG_WIDTH  parsed decimal distance.
- instruction_valid  out  1  one-cycle pulse; direction/magnitude valid in that cycle.
- parse_error  out  1  one-cycle pulse per malformed line.
- done  out  1  sticky; the final instruction has been emitted.

Behaviour:
- Clock and reset:
  - One clock, named clock.
  - Reset is asynchronous and active-low, named clear_n.
  - In reset, all state clears: state=IDLE, accumulator=0, digit count=0.
  - Output reset values: direction=0, magnitude=0, instruction_valid=0, parse_error=0, done=0, byte_ready=0.
  - byte_ready rises the first cycle after clear_n deasserts.
- Handshake:
  - A byte is accepted when byte_valid & byte_ready.
  - byte_ready=1 in IDLE, DIGITS and SKIP; byte_ready=0 in DONE.
  - Full throughput: one byte per cycle, no bubble.
- States and transitions on an accepted byte:
  - IDLE:
    - 'L'/'R' -> latch direction, clear accumulator and count -> DIGITS.
    - '\n' and '\r' ignored (blank lines legal).
    - Any other byte -> parse_error -> SKIP.
  - DIGITS:
    - '0'-'9' -> accumulator = accumulator*10 + (byte-0x30), count++.
    - '\r' ignored.
    - '\n' with count>=1 -> emit -> IDLE.
    - '\n' with count=0 -> parse_error -> IDLE.
    - Digit arriving when count=MAX_DIGITS -> parse_error -> SKIP.
    - Other byte -> parse_error -> SKIP.
  - SKIP: discard bytes until '\n' -> IDLE. No instruction is emitted for the errored line.
  - DONE: terminal; cleared only by reset.
- Emit timing:
  - direction/magnitude are registered.
  - instruction_valid is high exactly in the cycle after the terminating byte is accepted.
  - direction/magnitude hold their values until the next emit.
- Arithmetic:
  - accumulator is MAG_WIDTH+4 bits; digits are parsed from this accumulator.
  - magnitude = accumulator saturated to 2^MAG_WIDTH-1 when it exceeds the range.
  - A saturated value is still emitted; it is not an error.
- byte_last:
  - After the accepted byte is processed, move to DONE.
  - If a line is pending in DIGITS with count>=1 (no trailing newline), emit it; the byte itself counts if it is a digit.
  - done rises in the same cycle as that final instruction_valid, or one cycle after accept if nothing is emitted.
- Simultaneous events:
  - parse_error and instruction_valid are never high together.
  - clear_n asserted mid-line discards the partial line; no emit occurs.

Optional Feature:
- Macro: DAY1_PARSER_STATS_EN.
- When defined, add two outputs:
  - line_count[31:0]: increments on each instruction_valid.
  - error_count[15:0]: increments on each parse_error, saturating at 0xFFFF.
  - Both reset to 0 on clear_n.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package day1_pkg holds:
  - ASCII constants: CHAR_L=0x4C, CHAR_R=0x52, CHAR_LF=0x0A, CHAR_CR=0x0D, CHAR_0=0x30, CHAR_9=0x39.
  - DIAL_SIZE=100 and MAG_WIDTH default.
  - parser state enum {IDLE, DIGITS, SKIP, DONE}.
- One sub-module, day1_dec_accum: the digit accumulate/saturate datapath, with inputs clear, digit_en, digit[3:0] and outputs value and count.
- FSM and handshake stay in the top.

Test Plan:
- Stream "L68\nR14\n", byte_valid held high -> two pulses: (dir=0, mag=68), then (dir=1, mag=14). Each pulse occurs the cycle after its '\n' is accepted.
- Stream "R5\r\n\nL0\n" -> pulses (1, 5) then (0, 0). CR and the blank line are ignored; no parse_error.
- Stream "X12\nL7\n" -> parse_error pulse on 'X', no emit for the first line, then (0, 7).
- Stream "R99999\n" with MAG_WIDTH=16 -> mag=65535 (saturated), no error. "R123456\n" -> parse_error on the sixth digit, no emit.
- Stream "L3" with byte_last on '3' -> (0, 3) emitted; done=1 the same cycle; byte_ready=0 afterwards.
- Assert clear_n low after "R4" mid-line, release, stream "L1\n" -> only (0, 1) is emitted; every output was 0 during reset.
